// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- receive half of the UART peripheral.
//
// Recovers asynchronous serial frames from `rx` using an OVERSAMPLE x baud
// sample enable. Each completed character, with its parity and framing
// flags, is pushed into the RX queue with a one-clk strobe.
//
// Ports:
//   clk               system clock
//   reset             asynchronous, active-low reset
//   rx                serial line (idle high, asynchronous to clk)
//   sample_en         one-clk pulse at OVERSAMPLE x baud
//   data_bits_count   character length - 5 (5..8 bits)
//   parity_type       [0] parity enable, [1] parity seed (0 even, 1 odd)
//   double_stop_bits  1 = two stop bits
//   rx_queue_full     RX queue cannot accept a push
//   rx_queue_we       one-clk push strobe
//   rx_data           received character, right-aligned
//   parity_err        parity mismatch, valid with rx_queue_we
//   frame_err         a stop bit sampled low, valid with rx_queue_we
//   overrun           sticky: a character completed while the queue was full
//   busy              high whenever a frame is in progress
//
// Build option:
//   UART_RX_MAJORITY_EN  every bit decision is the 2-of-3 majority of the
//                        ticks just before, at and just after the bit centre.
//
// OVERSAMPLE must be a power of two, at least 8; SYNC_STAGES at least 2.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       sample_en,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  input  logic       rx_queue_full,
  output logic       rx_queue_we,
  output logic [7:0] rx_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
  } state_e;

  // Input synchroniser, reset to the idle line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Bit decision value and the tick at which the start bit is judged.
  logic bit_s;

`ifdef UART_RX_MAJORITY_EN
  // The decision is taken one tick after the centre so that the tick after
  // it is available; tcnt restarts there, so every later decision (at the
  // tcnt wrap) also lands one tick after its centre.
  localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2);
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         hist_q <= 2'b11;
    else if (sample_en) hist_q <= {hist_q[0], rxs};
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2 - 1);
  assign bit_s = rxs;
`endif

  state_e        state_q;
  logic          armed_q;
  logic [TW-1:0] tcnt_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          perr_q;
  logic          ferr_q;
  logic [1:0]    dbc_q;
  logic          pen_q;
  logic          seed_q;
  logic          dstop_q;

  logic [TW-1:0] tnext;
  logic          centre;
  logic [2:0]    last_bit;
  logic          last_stop;
  logic          stop_fe;

  assign tnext    = tcnt_q + TW'(1);
  // Bit centres follow the start decision by whole bit periods: tcnt wraps.
  assign centre   = sample_en && (tnext == '0);
  assign last_bit = {1'b0, dbc_q} + 3'd4;
  assign last_stop = (state_q == S_STOP2) || !dstop_q;
  assign stop_fe   = ((state_q == S_STOP2) & ferr_q) | ~bit_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b1;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      dbc_q       <= '0;
      pen_q       <= 1'b0;
      seed_q      <= 1'b0;
      dstop_q     <= 1'b0;
      rx_queue_we <= 1'b0;
      rx_data     <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_queue_we <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sample_en) begin
            if (rxs) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              // Frame config is frozen for the whole frame from here.
              state_q <= S_START;
              busy    <= 1'b1;
              tcnt_q  <= '0;
              dbc_q   <= data_bits_count;
              pen_q   <= parity_type[0];
              seed_q  <= parity_type[1];
              dstop_q <= double_stop_bits;
            end
          end
        end
        S_START: begin
          if (sample_en) begin
            if (tnext == START_TICK) begin
              tcnt_q <= '0;
              if (bit_s) begin
                // Line back high before mid start bit: noise, not a frame.
                state_q <= S_IDLE;
                busy    <= 1'b0;
              end else begin
                state_q <= S_DATA;
                bcnt_q  <= '0;
                par_q   <= seed_q;
                perr_q  <= 1'b0;
              end
            end else begin
              tcnt_q <= tnext;
            end
          end
        end
        S_DATA: begin
          if (sample_en) tcnt_q <= tnext;
          if (centre) begin
            shift_q <= {bit_s, shift_q[7:1]};
            par_q   <= par_q ^ bit_s;
            bcnt_q  <= bcnt_q + 3'd1;
            if (bcnt_q == last_bit) state_q <= pen_q ? S_PARITY : S_STOP1;
          end
        end
        S_PARITY: begin
          if (sample_en) tcnt_q <= tnext;
          if (centre) begin
            perr_q  <= bit_s ^ par_q;
            state_q <= S_STOP1;
          end
        end
        S_STOP1, S_STOP2: begin
          if (sample_en) tcnt_q <= tnext;
          if (centre) begin
            ferr_q <= stop_fe;
            if (!last_stop) begin
              state_q <= S_STOP2;
            end else begin
              // Outputs are registered here so the push is visible during DONE.
              state_q <= S_DONE;
              if (rx_queue_full) begin
                overrun <= 1'b1;
              end else begin
                rx_queue_we <= 1'b1;
                rx_data     <= shift_q >> (2'd3 - dbc_q);
                parity_err  <= perr_q;
                frame_err   <= stop_fe;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          // After a framing error the line may be stuck low (break); wait
          // for it to return high before looking for another start bit.
          armed_q <= ~ferr_q;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx. Frames are generated at the bit
// level; a frame-level model predicts each pushed character and its flags,
// and a per-cycle compare process checks every push and the held outputs.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       sample_en = 1'b0;
  logic [1:0] dbc = 2'd3;
  logic [1:0] ptype = 2'd0;
  logic       dstop = 1'b0;
  logic       qfull = 1'b0;

  logic       we;
  logic [7:0] rdata;
  logic       pe;
  logic       fe;
  logic       ovr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int sdiv = 1;
  int scnt = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t expq[$];
  exp_t last = '0;
  logic prev_we = 1'b0;
  logic prev_ovr = 1'b0;

  uart_rx dut (
    .clk              (clk),
    .reset            (rst_n),
    .rx               (rx),
    .sample_en        (sample_en),
    .data_bits_count  (dbc),
    .parity_type      (ptype),
    .double_stop_bits (dstop),
    .rx_queue_full    (qfull),
    .rx_queue_we      (we),
    .rx_data          (rdata),
    .parity_err       (pe),
    .frame_err        (fe),
    .overrun          (ovr),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Sample enable: one pulse every sdiv clocks.
  always @(negedge clk) begin
    scnt = (scnt + 1 >= sdiv) ? 0 : scnt + 1;
    sample_en = (scnt == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every push must match the model's next prediction,
  // and outputs hold their last pushed values in between.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      last = '0;
      prev_we = 1'b0;
      prev_ovr = 1'b0;
    end else begin
      if (we) begin
        if (expq.size() == 0) chk("unexpected_push", 1, 0);
        else last = expq.pop_front();
        chk("busy_at_push", busy, 1);
      end
      chk("rx_data", rdata, last.d);
      chk("parity_err", pe, last.pe);
      chk("frame_err", fe, last.fe);
      if (prev_we) chk("busy_after_push", busy, 0);
      if (prev_ovr) chk("overrun_sticky", ovr, 1);
      prev_we = we;
      prev_ovr = ovr;
    end
  end

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Send one frame with the current config. d_exp is the character the
  // receiver should see (differs from d only for the spike frame).
  task automatic send(input logic [7:0] d, input logic [7:0] d_exp, input logic pflip,
                      input logic s1, input logic s2, input logic spike, input logic scramble);
    int n, bt;
    logic pen, seed, ds, pb;
    logic [7:0] mask;
    logic [1:0] dbc_s, pt_s;
    logic ds_s;
    exp_t e;
    n    = int'(dbc) + 5;
    bt   = 16 * sdiv;
    pen  = ptype[0];
    seed = ptype[1];
    ds   = dstop;
    mask = 8'hFF >> (8 - n);
    // Correct parity bit: even -> XOR of data, odd -> its inverse.
    pb   = (^(d & mask)) ^ seed ^ pflip;
    e.d  = d_exp & mask;
    e.pe = pen & (pb ^ seed ^ (^(d_exp & mask)));
    e.fe = ~s1 | (ds & ~s2);
    if (!qfull) expq.push_back(e);
    dbc_s = dbc; pt_s = ptype; ds_s = dstop;
    drive(1'b0, bt);
    if (scramble) begin
      dbc = ~dbc; ptype = ~ptype; dstop = ~dstop;
    end
    for (int i = 0; i < n; i++) begin
      if (spike && d[i]) begin
        drive(1'b1, 7); drive(1'b0, 1); drive(1'b1, bt - 8);
      end else begin
        drive(d[i], bt);
      end
    end
    if (pen) drive(pb, bt);
    drive(s1, bt);
    if (ds) drive(s2, bt);
    dbc = dbc_s; ptype = pt_s; dstop = ds_s;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] spike_exp;
    repeat (4) @(negedge clk);
    chk("reset_we", we, 0);
    chk("reset_rx_data", rdata, 0);
    chk("reset_parity_err", pe, 0);
    chk("reset_frame_err", fe, 0);
    chk("reset_overrun", ovr, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    drive(1'b1, 20);

    // 8N1 0xA5
    dbc = 2'd3; ptype = 2'b00; dstop = 1'b0;
    send(8'hA5, 8'hA5, 0, 1, 1, 0, 0);
    drive(1'b1, 32);
    chk("a5_pending", expq.size(), 0);
    chk("a5_data", rdata, 8'hA5);
    chk("a5_flags", {pe, fe}, 2'b00);

    // 5-bit odd parity 0x13: correct parity bit, then flipped
    dbc = 2'd0; ptype = 2'b11;
    send(8'h13, 8'h13, 0, 1, 1, 0, 0);
    drive(1'b1, 32);
    chk("p13_data", rdata, 8'h13);
    chk("p13_perr_ok", pe, 0);
    send(8'h13, 8'h13, 1, 1, 1, 0, 0);
    drive(1'b1, 32);
    chk("p13_perr_bad", pe, 1);
    chk("p13_pending", expq.size(), 0);

    // 7E1 with config scrambled mid-frame; 6N1 at a slower sample rate
    dbc = 2'd2; ptype = 2'b01;
    send(8'h41, 8'h41, 0, 1, 1, 0, 1);
    drive(1'b1, 32);
    chk("e41_data", rdata, 8'h41);
    dbc = 2'd1; ptype = 2'b00; sdiv = 3;
    drive(1'b1, 8);
    send(8'h2A, 8'h2A, 0, 1, 1, 0, 0);
    drive(1'b1, 96);
    chk("s2a_data", rdata, 8'h2A);
    sdiv = 1;
    drive(1'b1, 8);

    // 8N2, second stop low, then line held low 40 bit times
    dbc = 2'd3; ptype = 2'b00; dstop = 1'b1;
    send(8'hC3, 8'hC3, 0, 1, 0, 0, 0);
    drive(1'b0, 40 * 16);
    chk("c3_data", rdata, 8'hC3);
    chk("c3_frame_err", fe, 1);
    chk("break_busy", busy, 0);
    chk("break_pending", expq.size(), 0);
    dstop = 1'b0;
    drive(1'b1, 32);
    send(8'h55, 8'h55, 0, 1, 1, 0, 0);
    drive(1'b1, 32);
    chk("r55_data", rdata, 8'h55);
    chk("r55_frame_err", fe, 0);

    // Start-bit glitch
    drive(1'b0, 4);
    drive(1'b1, 40);
    chk("glitch_busy", busy, 0);
    send(8'h3C, 8'h3C, 0, 1, 1, 0, 0);
    drive(1'b1, 32);
    chk("g3c_data", rdata, 8'h3C);

    // Queue full -> overrun, sticky
    qfull = 1'b1;
    chk("ovr_before", ovr, 0);
    send(8'hFF, 8'hFF, 0, 1, 1, 0, 0);
    drive(1'b1, 32);
    chk("ovr_set", ovr, 1);
    chk("ovr_hold_data", rdata, 8'h3C);
    qfull = 1'b0;
    drive(1'b1, 5);
    chk("ovr_after_clear", ovr, 1);

    // Reset mid-frame
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 8);
    #2 rst_n = 1'b0;
    rx = 1'b1;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_data", rdata, 0);
    chk("mid_rst_flags", {pe, fe}, 2'b00);
    chk("mid_rst_overrun", ovr, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 32);
    send(8'h81, 8'h81, 0, 1, 1, 0, 0);
    drive(1'b1, 32);
    chk("r81_data", rdata, 8'h81);

    // Single-tick low spike at each data-bit centre of 0xFF
`ifdef UART_RX_MAJORITY_EN
    spike_exp = 8'hFF;
`else
    spike_exp = 8'h00;
`endif
    send(8'hFF, spike_exp, 0, 1, 1, 1, 0);
    drive(1'b1, 32);
    chk("spike_data", rdata, spike_exp);
    chk("final_pending", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
